// File: rtl/trap_filter_sequencer_if.sv
// ---------------------------------------------------------------------------
// trap_filter_sequencer_if
//   Valid/ready bundle that carries the captured trapezoid peak from the
//   event sequencer to its consumer.
//
//   Signals:
//     peak_data  - captured maximum of the filter output (DATA_W bits)
//     peak_valid - peak_data holds a completed measurement
//     peak_ready - consumer accepts peak_data this cycle
//
//   Modports:
//     master - the sequencer (drives peak_data/peak_valid)
//     slave  - the consumer  (drives peak_ready)
// ---------------------------------------------------------------------------
interface trap_filter_sequencer_if #(
    parameter int DATA_W = 21
);
    logic [DATA_W-1:0] peak_data;
    logic              peak_valid;
    logic              peak_ready;

    modport master (
        output peak_data,
        output peak_valid,
        input  peak_ready
    );

    modport slave (
        input  peak_data,
        input  peak_valid,
        output peak_ready
    );
endinterface

// File: rtl/trap_filter_sequencer.sv
// ---------------------------------------------------------------------------
// trap_filter_sequencer
//   Event sequencer for a trapezoidal shaping filter. Holds the filter in
//   reset between events, triggers on an ADC sample above THRESHOLD, waits
//   for the flat top, captures the peak filter output over a window and
//   presents it on a valid/ready port, then flushes the filter.
//
//   Ports:
//     clk          - system clock
//     reset        - asynchronous active-low reset
//     input_data   - raw ADC sample (same source that feeds the filter)
//     filt_data    - filter output, SIZE_FILTER_DATA+1 bits
//     filt_reset   - active-low reset to the filter (registered)
//     busy         - high in every state except IDLE (registered)
//     peak_if      - master side of the peak valid/ready bundle
//     event_count  - accepted events, saturating
//     pileup_count - rejected (piled-up) events, saturating
//
//   Build option:
//     TRAP_SEQ_PILEUP_REJECT_EN - when defined, a second threshold crossing
//     after the input has dropped back below THRESHOLD during SETTLE or
//     MEASURE aborts the event straight to FLUSH and bumps pileup_count.
//     When undefined the pileup logic is absent and pileup_count reads 0.
// ---------------------------------------------------------------------------
module trap_filter_sequencer #(
    parameter int SIZE_ADC_DATA    = 12,
    parameter int SIZE_FILTER_DATA = 20,
    parameter int THRESHOLD        = 64,
    parameter int SETTLE_CYCLES    = 8,
    parameter int FLAT_CYCLES      = 4,
    parameter int FLUSH_CYCLES     = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [SIZE_ADC_DATA-1:0]    input_data,
    input  logic [SIZE_FILTER_DATA:0]   filt_data,
    output logic                        filt_reset,
    output logic                        busy,
    trap_filter_sequencer_if.master     peak_if,
    output logic [15:0]                 event_count,
    output logic [15:0]                 pileup_count
);

    typedef enum logic [2:0] {
        ST_FLUSH   = 3'd0,
        ST_IDLE    = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_MEASURE = 3'd3,
        ST_HOLD    = 3'd4
    } state_t;

    localparam logic [SIZE_ADC_DATA-1:0] THRESH_VAL  = SIZE_ADC_DATA'(THRESHOLD);
    localparam logic [7:0]               SETTLE_LOAD = 8'(SETTLE_CYCLES);
    localparam logic [7:0]               FLAT_LOAD   = 8'(FLAT_CYCLES);
    localparam logic [7:0]               FLUSH_LOAD  = 8'(FLUSH_CYCLES);

    state_t                    state_r;
    state_t                    state_s;
    logic [7:0]                cnt_r;
    logic [7:0]                cnt_s;
    logic [SIZE_FILTER_DATA:0] peak_r;
    logic [SIZE_FILTER_DATA:0] peak_s;
    logic                      peak_valid_r;
    logic                      filt_reset_r;
    logic                      busy_r;
    logic                      trig_r;
    logic                      above_s;
    logic                      accept_s;
    logic                      pileup_s;
    logic [15:0]               event_count_r;

    assign above_s = (input_data > THRESH_VAL);

`ifdef TRAP_SEQ_PILEUP_REJECT_EN
    logic        window_s;
    logic        below_r;
    logic [15:0] pileup_count_r;

    assign window_s = (state_r == ST_SETTLE) || (state_r == ST_MEASURE);
    // below_r only reflects earlier edges, so a dip and re-crossing must span two edges
    assign pileup_s = window_s && below_r && above_s;

    // Rearm flag: remembers that the input fell back to baseline inside the window
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            below_r <= 1'b0;
        end else if (state_r == ST_IDLE) begin
            below_r <= 1'b0;
        end else if (window_s && !above_s) begin
            below_r <= 1'b1;
        end else begin
            below_r <= below_r;
        end
    end

    // Saturating count of events aborted by pileup
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pileup_count_r <= 16'd0;
        end else if (pileup_s && (pileup_count_r != 16'hFFFF)) begin
            pileup_count_r <= pileup_count_r + 16'd1;
        end else begin
            pileup_count_r <= pileup_count_r;
        end
    end

    assign pileup_count = pileup_count_r;
`else
    assign pileup_s     = 1'b0;
    assign pileup_count = 16'd0;
`endif

    // Next-state, cycle counter and running-peak decode
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        peak_s   = peak_r;
        accept_s = 1'b0;
        case (state_r)
            ST_FLUSH: begin
                if (cnt_r <= 8'd1) begin
                    state_s = ST_IDLE;
                    cnt_s   = 8'd0;
                end else begin
                    cnt_s = cnt_r - 8'd1;
                end
            end
            ST_IDLE: begin
                // trig_r is the registered threshold decision taken while idle
                if (trig_r) begin
                    state_s = ST_SETTLE;
                    cnt_s   = SETTLE_LOAD;
                    peak_s  = '0;
                end else begin
                    cnt_s = 8'd0;
                end
            end
            ST_SETTLE: begin
                if (pileup_s) begin
                    state_s = ST_FLUSH;
                    cnt_s   = FLUSH_LOAD;
                end else if (cnt_r <= 8'd1) begin
                    state_s = ST_MEASURE;
                    cnt_s   = FLAT_LOAD;
                end else begin
                    cnt_s = cnt_r - 8'd1;
                end
            end
            ST_MEASURE: begin
                if (filt_data > peak_r) begin
                    peak_s = filt_data;
                end else begin
                    peak_s = peak_r;
                end
                if (pileup_s) begin
                    state_s = ST_FLUSH;
                    cnt_s   = FLUSH_LOAD;
                end else if (cnt_r <= 8'd1) begin
                    state_s = ST_HOLD;
                    cnt_s   = 8'd0;
                end else begin
                    cnt_s = cnt_r - 8'd1;
                end
            end
            ST_HOLD: begin
                if (peak_valid_r && peak_if.peak_ready) begin
                    state_s  = ST_FLUSH;
                    cnt_s    = FLUSH_LOAD;
                    accept_s = 1'b1;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: begin
                state_s = ST_FLUSH;
                cnt_s   = FLUSH_LOAD;
            end
        endcase
    end

    // State, counter, peak and registered output flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_FLUSH;
            cnt_r        <= FLUSH_LOAD;
            peak_r       <= '0;
            peak_valid_r <= 1'b0;
            filt_reset_r <= 1'b0;
            busy_r       <= 1'b1;
            trig_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            peak_r       <= peak_s;
            peak_valid_r <= (state_s == ST_HOLD);
            filt_reset_r <= (state_s != ST_FLUSH);
            busy_r       <= (state_s != ST_IDLE);
            trig_r       <= (state_r == ST_IDLE) && above_s;
        end
    end

    // Saturating count of events handed to the consumer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            event_count_r <= 16'd0;
        end else if (accept_s && (event_count_r != 16'hFFFF)) begin
            event_count_r <= event_count_r + 16'd1;
        end else begin
            event_count_r <= event_count_r;
        end
    end

    assign filt_reset         = filt_reset_r;
    assign busy               = busy_r;
    assign event_count        = event_count_r;
    assign peak_if.peak_data  = peak_r;
    assign peak_if.peak_valid = peak_valid_r;

endmodule

// File: tb/tb_trap_filter_sequencer.sv
// ---------------------------------------------------------------------------
// tb_trap_filter_sequencer
//   Segment-based bench. Each segment fills per-edge stimulus arrays, runs a
//   timeline reference model over them (event start, window bounds, transfer
//   edge found by scanning the arrays), pushes expected peak transfers into a
//   queue, then releases reset and drives the arrays. A negedge monitor
//   compares per-edge flags/counters and pops the queue on each transfer.
//   Each segment ends with an asynchronous reset check.
// ---------------------------------------------------------------------------
module tb_trap_filter_sequencer;

    localparam int S    = 8;
    localparam int F    = 4;
    localparam int FL   = 16;
    localparam int THR  = 64;
    localparam int MAXE = 1600;

    typedef struct packed {
        logic [20:0] peak;
        logic [31:0] t;
    } txn_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] input_data = 12'd0;
    logic [20:0] filt_data = 21'd0;
    logic        filt_reset;
    logic        busy;
    logic [15:0] event_count;
    logic [15:0] pileup_count;

    trap_filter_sequencer_if #(.DATA_W(21)) pif ();

    trap_filter_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .input_data   (input_data),
        .filt_data    (filt_data),
        .filt_reset   (filt_reset),
        .busy         (busy),
        .peak_if      (pif),
        .event_count  (event_count),
        .pileup_count (pileup_count)
    );

    always #5 clk = ~clk;

    logic [11:0] in_a   [0:MAXE];
    logic [20:0] filt_a [0:MAXE];
    bit          rdy_a  [0:MAXE];
    bit          exp_fr    [0:MAXE];
    bit          exp_busy  [0:MAXE];
    bit          exp_valid [0:MAXE];
    int          exp_evc   [0:MAXE];
    int          exp_pc    [0:MAXE];
    txn_t        exp_q[$];
    int          evc_m;
    int          pc_m;
    int          n_checks = 0;
    int          n_err = 0;
    int          edge_n = 0;
    bit          mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n, act, expv);
        end
    endtask

    task automatic mark(input int a, input int b, input bit fr, input bit bs, input bit vl, input int n);
        for (int k = a; k <= b && k <= n; k++) begin
            exp_fr[k]    = fr;
            exp_busy[k]  = bs;
            exp_valid[k] = vl;
            exp_evc[k]   = evc_m;
            exp_pc[k]    = pc_m;
        end
    endtask

    // Timeline model: index k means "state just after edge k" (k=0 is reset).
    task automatic run_model(input int n);
        int   t;
        int   e0;
        int   h;
        int   tt;
        int   kp;
        bit   pile;
        bit   below;
        logic [20:0] pk;
        txn_t tx;
        evc_m = 0;
        pc_m  = 0;
        t     = 0;
        while (t <= n) begin
            mark(t, t + FL - 1, 1'b0, 1'b1, 1'b0, n);
            e0 = t + FL + 1;
            while (e0 <= n && in_a[e0] <= 12'(THR)) e0++;
            if (e0 > n) begin
                mark(t + FL, n, 1'b1, 1'b0, 1'b0, n);
                break;
            end
            mark(t + FL, e0, 1'b1, 1'b0, 1'b0, n);
            h     = e0 + S + F + 1;
            pile  = 1'b0;
            below = 1'b0;
            kp    = 0;
`ifdef TRAP_SEQ_PILEUP_REJECT_EN
            for (int j = e0 + 2; j <= h && j <= n && !pile; j++) begin
                if (in_a[j] <= 12'(THR)) below = 1'b1;
                else if (below) begin
                    pile = 1'b1;
                    kp   = j;
                end
            end
`endif
            if (pile) begin
                mark(e0 + 1, kp - 1, 1'b1, 1'b1, 1'b0, n);
                if (pc_m < 65535) pc_m++;
                t = kp;
                continue;
            end
            mark(e0 + 1, h - 1, 1'b1, 1'b1, 1'b0, n);
            if (h > n) break;
            pk = 21'd0;
            for (int j = e0 + S + 2; j <= h; j++) if (filt_a[j] > pk) pk = filt_a[j];
            tt = h + 1;
            while (tt <= n && !rdy_a[tt]) tt++;
            mark(h, tt - 1, 1'b1, 1'b1, 1'b1, n);
            tx.peak = pk;
            tx.t    = 32'(tt);
            exp_q.push_back(tx);
            if (tt > n) break;
            if (evc_m < 65535) evc_m++;
            t = tt;
        end
    endtask

    task automatic fill_default(input int n);
        for (int k = 0; k <= n; k++) begin
            in_a[k]   = 12'd0;
            filt_a[k] = 21'h1F0000;
            rdy_a[k]  = 1'b1;
        end
    endtask

    task automatic gen_random(input int n);
        int k;
        k = 1;
        while (k <= n) begin
            int len;
            bit hi;
            len = int'($urandom_range(1, 24));
            hi  = 1'($urandom_range(0, 1));
            for (int j = 0; j < len && k <= n; j++) begin
                in_a[k] = hi ? 12'($urandom_range(65, 4095)) : 12'($urandom_range(0, 64));
                case ($urandom_range(0, 9))
                    0:       filt_a[k] = 21'd0;
                    1:       filt_a[k] = 21'h1FFFFF;
                    default: filt_a[k] = 21'($urandom);
                endcase
                k++;
            end
        end
        k = 1;
        while (k <= n) begin
            int len;
            bit r;
            len = int'($urandom_range(1, 25));
            r   = ($urandom_range(0, 2) != 0);
            for (int j = 0; j < len && k <= n; j++) begin
                rdy_a[k] = r;
                k++;
            end
        end
    endtask

    task automatic run_segment(input int n);
        exp_q.delete();
        run_model(n);
        input_data     = in_a[1];
        filt_data      = filt_a[1];
        pif.peak_ready = rdy_a[1];
        @(posedge clk);
        #2;
        edge_n = 0;
        reset  = 1'b1;
        mon_en = 1'b1;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            edge_n = k;
            #2;
            if (k < n) begin
                input_data     = in_a[k + 1];
                filt_data      = filt_a[k + 1];
                pif.peak_ready = rdy_a[k + 1];
            end
        end
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        if (exp_q.size() > 0 && exp_q[exp_q.size() - 1].t > 32'(n)) void'(exp_q.pop_back());
        chk("pending_transfers", 32'(exp_q.size()), 32'd0);
        reset = 1'b0;
        #1;
        chk("async_peak_valid", 32'(pif.peak_valid), 32'd0);
        chk("async_peak_data", 32'(pif.peak_data), 32'd0);
        chk("async_filt_reset", 32'(filt_reset), 32'd0);
        chk("async_busy", 32'(busy), 32'd1);
        chk("async_event_count", 32'(event_count), 32'd0);
        chk("async_pileup_count", 32'(pileup_count), 32'd0);
        repeat (2) @(posedge clk);
    endtask

    // Monitor: per-edge flags and counters, plus scoreboard pop on transfer
    always @(negedge clk) begin
        if (mon_en) begin
            chk("filt_reset", 32'(filt_reset), 32'(exp_fr[edge_n]));
            chk("busy", 32'(busy), 32'(exp_busy[edge_n]));
            chk("peak_valid", 32'(pif.peak_valid), 32'(exp_valid[edge_n]));
            chk("event_count", 32'(event_count), 32'(exp_evc[edge_n]));
            chk("pileup_count", 32'(pileup_count), 32'(exp_pc[edge_n]));
            if (pif.peak_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL peak_valid_unexpected at edge %0d: got valid with no expected transfer", edge_n);
                end else begin
                    chk("peak_data", 32'(pif.peak_data), 32'(exp_q[0].peak));
                    if (pif.peak_ready) begin
                        chk("transfer_edge", 32'(edge_n + 1), exp_q[0].t);
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        pif.peak_ready = 1'b0;
        reset = 1'b0;
        repeat (3) @(posedge clk);

        // Directed: threshold boundary, single pulse, backpressure, pileup
        fill_default(400);
        for (int k = 1; k <= 130; k++) in_a[k] = 12'd64;
        in_a[131] = 12'd65;
        for (int k = 132; k <= 150; k++) in_a[k] = 12'd200;
        filt_a[141] = 21'd10; filt_a[142] = 21'd30; filt_a[143] = 21'd50; filt_a[144] = 21'd40;
        for (int k = 200; k <= 220; k++) in_a[k] = 12'd200;
        filt_a[210] = 21'd10; filt_a[211] = 21'd30; filt_a[212] = 21'd50; filt_a[213] = 21'd40;
        for (int k = 214; k <= 233; k++) rdy_a[k] = 1'b0;
        for (int k = 300; k <= 320; k++) in_a[k] = 12'd200;
        in_a[306] = 12'd10;
        filt_a[310] = 21'd1; filt_a[311] = 21'd2; filt_a[312] = 21'd3; filt_a[313] = 21'd4;
        run_segment(400);

        // Reset asserted during MEASURE
        fill_default(31);
        for (int k = 20; k <= 31; k++) in_a[k] = 12'd200;
        filt_a[30] = 21'd1234;
        filt_a[31] = 21'd77;
        run_segment(31);

        // Reset asserted during HOLD under backpressure
        fill_default(40);
        for (int k = 20; k <= 40; k++) in_a[k] = 12'd200;
        for (int k = 0; k <= 40; k++) rdy_a[k] = 1'b0;
        run_segment(40);

        // Randomized segments
        for (int s = 0; s < 4; s++) begin
            fill_default(1500);
            gen_random(1500);
            run_segment(1500);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/trap_filter_sequencer.md
# trap_filter_sequencer

Event sequencer for the trapezoidal shaping filter. It watches raw ADC samples for a threshold crossing and holds the filter in reset between events. It waits for the trapezoid to reach its flat top, captures the peak filter output over a measurement window, and presents it on a valid/ready port. After each event it flushes the filter so the next pulse starts from a clean baseline.

## Interface
Parameters:
- SIZE_ADC_DATA, 12, ADC sample width.
- SIZE_FILTER_DATA, 20, filter output is SIZE_FILTER_DATA+1 bits wide.
- THRESHOLD, 64, trigger level; triggers on input_data > THRESHOLD, unsigned.
- SETTLE_CYCLES, 8, cycles from trigger to start of the flat top; legal range 1..255.
- FLAT_CYCLES, 4, length of the peak-search window; legal range 1..255.
- FLUSH_CYCLES, 16, filter reset hold length; legal range 1..255.

Ports (one clock; reset is asynchronous and active-low):
- clk, in, 1, system clock.
- reset, in, 1, asynchronous active-low reset.
- input_data, in, SIZE_ADC_DATA, raw ADC sample; the filter is fed from the same source.
- filt_data, in, SIZE_FILTER_DATA+1, filter output.
- filt_reset, out, 1, active-low reset driven to the filter; registered.
- busy, out, 1, high in every state except IDLE.
- peak_data, out, SIZE_FILTER_DATA+1, captured maximum of filt_data.
- peak_valid, out, 1, peak_data valid.
- peak_ready, in, 1, consumer accepts peak_data.
- event_count, out, 16, accepted events; saturates at 0xFFFF.
- pileup_count, out, 16, rejected events; saturates at 0xFFFF.

## Operation
- States: FLUSH, IDLE, SETTLE, MEASURE, HOLD.
- FLUSH:
  - filt_reset=0; down-counter runs FLUSH_CYCLES cycles.
  - Then go to IDLE with filt_reset=1.
- IDLE: when input_data > THRESHOLD at a clock edge, go to SETTLE. Clear the peak register and the rearm flags.
- SETTLE: lasts exactly SETTLE_CYCLES cycles, then go to MEASURE.
- MEASURE:
  - Lasts exactly FLAT_CYCLES cycles.
  - Each cycle, peak = max(peak, filt_data), unsigned compare. peak starts at 0.
  - Then go to HOLD.
- HOLD:
  - peak_valid=1; peak_data is stable until the transfer.
  - Transfer on peak_valid && peak_ready. On transfer, increment event_count (saturating) and go to FLUSH.
- Pileup detection covers SETTLE and MEASURE:
  - Set the "below" flag when input_data <= THRESHOLD.
  - If the below flag is set and input_data > THRESHOLD, a pileup has occurred.
- No new trigger is accepted outside IDLE.
- Counters saturate and never wrap.

## Timing
- Reset values: filt_reset=0, busy=1, peak_data=0, peak_valid=0, event_count=0, pileup_count=0. State is FLUSH with the counter loaded to FLUSH_CYCLES.
- Reset asserted mid-event: peak_data and peak_valid clear immediately (asynchronously) and the state goes to FLUSH. The pending event is lost and counted in neither counter.
- Trigger sampled at edge E0:
  - SETTLE covers the cycles after E1 through E1+SETTLE_CYCLES-1.
  - MEASURE samples filt_data on the next FLAT_CYCLES edges.
  - peak_valid rises at edge E0+SETTLE_CYCLES+FLAT_CYCLES+1.
- With peak_ready held at 1, HOLD lasts exactly 1 cycle.
- Pileup, the trigger threshold test, and the MEASURE compare are all single-cycle registered decisions.

## Configuration
- TRAP_SEQ_PILEUP_REJECT_EN defined:
  - On pileup detection, immediately go to FLUSH and increment pileup_count (saturating).
  - peak_valid is never asserted for that event.
- TRAP_SEQ_PILEUP_REJECT_EN undefined:
  - Pileup logic is absent and pileup_count is tied to 0.
  - Every triggered event completes to HOLD.

## Test plan
- Reset release: filt_reset stays 0 for 16 cycles, then 1. busy then falls; both counters read 0.
- input_data=64 held for 100 cycles: no trigger, stays in IDLE. input_data=65: trigger, busy=1 next cycle.
- Single pulse:
  - Stimulus: trigger at E0; filt_data=10,30,50,40 during MEASURE.
  - Required: peak_valid at E0+13, peak_data=50, filt_reset low for 16 cycles after the accept, event_count=1.
- Backpressure: peak_ready=0 for 20 cycles. peak_valid and peak_data=50 are held; FLUSH starts only after the cycle where peak_ready=1.
- Pileup:
  - Stimulus: input 200, then 10, then 200 during SETTLE.
  - With TRAP_SEQ_PILEUP_REJECT_EN: FLUSH next cycle, pileup_count=1, no peak_valid.
  - Without it: the event completes and event_count=1.
- Async reset asserted during MEASURE: outputs clear with no clock edge, and after release the FLUSH sequence repeats.
